// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller: RAW stall detection against an
// EX/MEM/WB destination scoreboard, plus branch/jump flush control.
module pipeline_hazard_controller (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        id_valid,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic [4:0]  id_dest,
    input  logic        id_reg_write,
    input  logic        ex_branch,
    input  logic        ex_zero,
    input  logic        ex_jump,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        idex_bubble,
    output logic        flush_ifid,
    output logic        PC_sel,
    output logic [1:0]  hazard_state,
    output logic [15:0] stall_count,
    output logic [15:0] flush_count
);

    localparam logic [1:0] ST_RUN   = 2'b00;
    localparam logic [1:0] ST_STALL = 2'b01;
    localparam logic [1:0] ST_FLUSH = 2'b10;

    // Scoreboard entries: index 0 = EX, 1 = MEM, 2 = WB.
    logic [2:0] sb_valid;
    logic [2:0] sb_rw;
    logic [4:0] sb_dest [3];

    logic        raw;
    logic        taken;
    logic        stall;
    logic [1:0]  state_q;
    logic [1:0]  state_d;
    logic [15:0] stall_q;
    logic [15:0] flush_q;

    // RAW match of the ID sources against every in-flight writer.
    always_comb begin
        raw = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (sb_valid[i] && sb_rw[i] && (sb_dest[i] != 5'd0)) begin
                if ((id_uses_rs && (id_rs == sb_dest[i])) ||
                    (id_uses_rt && (id_rt == sb_dest[i]))) begin
                    raw = 1'b1;
                end
            end
        end
        raw = raw & id_valid;
    end

    assign taken = ex_jump | (ex_branch & ex_zero);
    assign stall = raw & ~taken;

    // Pipeline control; a taken redirect overrides any stall.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_bubble = 1'b0;
        flush_ifid  = 1'b0;
        PC_sel      = 1'b0;
        state_d     = ST_RUN;
        unique case (1'b1)
            taken: begin
                idex_bubble = 1'b1;
                flush_ifid  = 1'b1;
                PC_sel      = 1'b1;
                state_d     = ST_FLUSH;
            end
            stall: begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
                state_d     = ST_STALL;
            end
            default: begin
                state_d     = ST_RUN;
            end
        endcase
    end

    // Scoreboard shift EX->MEM->WB; a bubble enters EX as invalid.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sb_valid <= 3'b000;
            sb_rw    <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                sb_dest[i] <= 5'd0;
            end
        end else begin
            sb_valid[2] <= sb_valid[1];
            sb_rw[2]    <= sb_rw[1];
            sb_dest[2]  <= sb_dest[1];
            sb_valid[1] <= sb_valid[0];
            sb_rw[1]    <= sb_rw[0];
            sb_dest[1]  <= sb_dest[0];
            sb_valid[0] <= id_valid & ~idex_bubble;
            sb_rw[0]    <= id_reg_write;
            sb_dest[0]  <= id_dest;
        end
    end

    // Registered state and saturating stall/flush event counters.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_RUN;
            stall_q <= 16'd0;
            flush_q <= 16'd0;
        end else begin
            state_q <= state_d;
            if (stall && (stall_q != 16'hFFFF)) begin
                stall_q <= stall_q + 16'd1;
            end
            if (taken && (flush_q != 16'hFFFF)) begin
                flush_q <= flush_q + 16'd1;
            end
        end
    end

    assign hazard_state = state_q;
    assign stall_count  = stall_q;
    assign flush_count  = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench for pipeline_hazard_controller: directed hazard,
// flush, saturation and reset cases followed by random traffic.
module tb_pipeline_hazard_controller;

    typedef struct {
        bit       rst;
        bit       iv;
        bit [4:0] rs;
        bit [4:0] rt;
        bit       urs;
        bit       urt;
        bit [4:0] dst;
        bit       rw;
        bit       br;
        bit       z;
        bit       j;
    } stim_t;

    typedef struct {
        bit        pcw;
        bit        ifw;
        bit        bub;
        bit        fl;
        bit        sel;
        bit [1:0]  st;
        bit [15:0] sc;
        bit [15:0] fc;
    } exp_t;

    typedef struct {
        bit       v;
        bit [4:0] d;
        bit       w;
    } wr_t;

    logic        clock;
    logic        reset_n;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rs;
    logic        id_uses_rt;
    logic [4:0]  id_dest;
    logic        id_reg_write;
    logic        ex_branch;
    logic        ex_zero;
    logic        ex_jump;
    logic        pc_write;
    logic        ifid_write;
    logic        idex_bubble;
    logic        flush_ifid;
    logic        PC_sel;
    logic [1:0]  hazard_state;
    logic [15:0] stall_count;
    logic [15:0] flush_count;

    int checks = 0;
    int errors = 0;

    exp_t      expq [$];
    wr_t       hist [$];
    bit [1:0]  m_st;
    bit [15:0] m_sc;
    bit [15:0] m_fc;

    pipeline_hazard_controller dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rs   (id_uses_rs),
        .id_uses_rt   (id_uses_rt),
        .id_dest      (id_dest),
        .id_reg_write (id_reg_write),
        .ex_branch    (ex_branch),
        .ex_zero      (ex_zero),
        .ex_jump      (ex_jump),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .idex_bubble  (idex_bubble),
        .flush_ifid   (flush_ifid),
        .PC_sel       (PC_sel),
        .hazard_state (hazard_state),
        .stall_count  (stall_count),
        .flush_count  (flush_count)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: compares DUT outputs against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            #3;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("pc_write", int'(pc_write), int'(e.pcw));
                chk("ifid_write", int'(ifid_write), int'(e.ifw));
                chk("idex_bubble", int'(idex_bubble), int'(e.bub));
                chk("flush_ifid", int'(flush_ifid), int'(e.fl));
                chk("PC_sel", int'(PC_sel), int'(e.sel));
                chk("hazard_state", int'(hazard_state), int'(e.st));
                chk("stall_count", int'(stall_count), int'(e.sc));
                chk("flush_count", int'(flush_count), int'(e.fc));
            end
        end
    end

    function automatic stim_t mk(bit iv, int rs, bit urs, int rt, bit urt,
                                 int dst, bit rw, bit br, bit z, bit j);
        stim_t s;
        s.rst = 1'b1;
        s.iv  = iv;
        s.rs  = rs[4:0];
        s.urs = urs;
        s.rt  = rt[4:0];
        s.urt = urt;
        s.dst = dst[4:0];
        s.rw  = rw;
        s.br  = br;
        s.z   = z;
        s.j   = j;
        return s;
    endfunction

    function automatic stim_t idle();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic stim_t prod(int dst);
        return mk(1, 0, 0, 0, 0, dst, 1, 0, 0, 0);
    endfunction

    function automatic stim_t rd(int rs);
        return mk(1, rs, 1, 0, 0, 9, 1, 0, 0, 0);
    endfunction

    // Drive one cycle, predict from the rules, then advance the model.
    task automatic step(input stim_t s, input bit frc);
        exp_t e;
        bit   tk;
        bit   hz;
        wr_t  w;
        @(negedge clock);
        reset_n      = s.rst;
        id_valid     = s.iv;
        id_rs        = s.rs;
        id_rt        = s.rt;
        id_uses_rs   = s.urs;
        id_uses_rt   = s.urt;
        id_dest      = s.dst;
        id_reg_write = s.rw;
        ex_branch    = s.br;
        ex_zero      = s.z;
        ex_jump      = s.j;
        if (!s.rst) begin
            hist.delete();
            m_st = 2'd0;
            m_sc = 16'd0;
            m_fc = 16'd0;
        end
        tk = s.j || (s.br && s.z);
        hz = 1'b0;
        for (int i = 0; i < hist.size() && i < 3; i++) begin
            if (hist[i].v && hist[i].w && hist[i].d != 0 &&
                ((s.urs && s.rs == hist[i].d) || (s.urt && s.rt == hist[i].d)))
                hz = s.iv;
        end
        if (tk) hz = 1'b0;
        e.pcw = !hz;
        e.ifw = !hz;
        e.bub = tk || hz;
        e.fl  = tk;
        e.sel = tk;
        e.st  = m_st;
        e.sc  = m_sc;
        e.fc  = m_fc;
        #1;
        expq.push_back(e);
        if (frc) begin
            #4;
            force dut.stall_q = 16'hFFFE;
            #1;
            release dut.stall_q;
            m_sc = 16'hFFFE;
        end
        if (s.rst) begin
            w.v = s.iv && !(tk || hz);
            w.d = s.dst;
            w.w = s.rw;
            hist.push_front(w);
            if (hist.size() > 3) void'(hist.pop_back());
            m_st = tk ? 2'd2 : (hz ? 2'd1 : 2'd0);
            if (hz && m_sc != 16'hFFFF) m_sc++;
            if (tk && m_fc != 16'hFFFF) m_fc++;
        end
    endtask

    task automatic idles(input int n);
        for (int i = 0; i < n; i++) step(idle(), 0);
    endtask

    initial begin
        stim_t s;
        int    wait_cyc;
        reset_n = 1'b0;
        id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
        id_dest = 0; id_reg_write = 0; ex_branch = 0; ex_zero = 0; ex_jump = 0;
        m_st = 0; m_sc = 0; m_fc = 0;

        s = idle();
        s.rst = 0;
        step(s, 0);
        step(s, 0);
        idles(2);

        // Back-to-back producer/consumer of r5: three stall cycles.
        step(prod(5), 0);
        for (int i = 0; i < 4; i++) step(rd(5), 0);
        idles(3);

        // Consumer two instructions behind: two stall cycles.
        step(prod(5), 0);
        step(mk(1, 1, 1, 2, 1, 3, 1, 0, 0, 0), 0);
        for (int i = 0; i < 3; i++) step(rd(5), 0);
        idles(3);

        // rt-side dependency.
        step(prod(12), 0);
        for (int i = 0; i < 4; i++) step(mk(1, 3, 1, 12, 1, 4, 0, 0, 0, 0), 0);
        idles(3);

        // Branch taken, branch not taken, jump.
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0), 0);
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 0);
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 0);
        idles(2);

        // Taken and RAW together: flush wins.
        step(prod(6), 0);
        step(mk(1, 6, 1, 0, 0, 7, 1, 0, 0, 1), 0);
        step(rd(6), 0);
        step(rd(6), 0);
        idles(3);

        // Register 0 never stalls.
        step(prod(0), 0);
        step(mk(1, 0, 1, 0, 1, 8, 1, 0, 0, 0), 0);
        idles(2);

        // Saturation at 16'hFFFF.
        step(prod(7), 0);
        step(rd(7), 1);
        step(rd(7), 0);
        step(rd(7), 0);
        step(rd(7), 0);
        idles(3);

        // Reset pulse mid-stall.
        step(prod(4), 0);
        step(rd(4), 0);
        s = rd(4);
        s.rst = 0;
        step(s, 0);
        step(rd(4), 0);
        idles(2);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            s.rst = 1'b1;
            s.iv  = ($urandom % 4) != 0;
            s.rs  = 5'($urandom_range(0, 7));
            s.rt  = 5'($urandom_range(0, 7));
            s.urs = $urandom % 2;
            s.urt = $urandom % 2;
            s.dst = 5'($urandom_range(0, 7));
            s.rw  = ($urandom % 3) != 0;
            s.br  = ($urandom % 8) == 0;
            s.z   = $urandom % 2;
            s.j   = ($urandom % 20) == 0;
            if (($urandom % 150) == 0) s.rst = 1'b0;
            step(s, 0);
        end
        idles(2);

        wait_cyc = 0;
        while (expq.size() > 0 && wait_cyc < 10) begin
            @(negedge clock);
            wait_cyc++;
        end
        @(negedge clock);
        #5;
        if (expq.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", expq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
